// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state codes, opcodes and select-key encodings for the multicycle control unit
package mc_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic       IORD_PC        = 1'b0;
    localparam logic       IORD_ALUOUT    = 1'b1;
    localparam logic [1:0] REG_DST_RT     = 2'b00;
    localparam logic [1:0] REG_DST_RD     = 2'b01;
    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
    localparam logic       ALU_A_PC       = 1'b0;
    localparam logic       ALU_A_REG      = 1'b1;
    localparam logic [1:0] ALU_B_REG      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR     = 2'b01;
    localparam logic [1:0] ALU_B_EXT      = 2'b10;
    localparam logic [1:0] ALU_B_BR_OFS   = 2'b11;
    localparam logic       EXT_SIGN       = 1'b0;
    localparam logic       EXT_ZERO       = 1'b1;
    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_SUB     = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT   = 2'b10;
    localparam logic [1:0] ALU_OP_OR      = 2'b11;
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst_sel;
        logic [1:0] mem_to_reg_sel;
        logic       alu_src_a_sel;
        logic [1:0] alu_src_b_sel;
        logic       ext_sel;
        logic [1:0] alu_op;
        logic [1:0] pc_src_sel;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW)  ||
               (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_ORI)   || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - control unit to datapath bundle; MC_CTRL_MEM_WAIT_EN adds mem_ready
interface mc_ctrl_fsm_if;
    import mc_ctrl_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic               zero;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic               mem_ready;
`endif
    logic               pc_en;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         reg_dst_sel;
    logic [1:0]         mem_to_reg_sel;
    logic               alu_src_a_sel;
    logic [1:0]         alu_src_b_sel;
    logic               ext_sel;
    logic [1:0]         alu_op;
    logic [1:0]         pc_src_sel;
    logic               instr_done;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport ctrl (
        input  opcode, zero,
`ifdef MC_CTRL_MEM_WAIT_EN
        input  mem_ready,
`endif
        output pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst_sel, mem_to_reg_sel, alu_src_a_sel, alu_src_b_sel,
               ext_sel, alu_op, pc_src_sel, instr_done, illegal_op, state
    );

    modport dp (
        output opcode, zero,
`ifdef MC_CTRL_MEM_WAIT_EN
        output mem_ready,
`endif
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst_sel, mem_to_reg_sel, alu_src_a_sel, alu_src_b_sel,
               ext_sel, alu_op, pc_src_sel, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state+opcode to control word decoder
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    output ctrl_word_t      cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read      = 1'b1;
                cw.ir_write      = 1'b1;
                cw.pc_write      = 1'b1;
                cw.iord          = IORD_PC;
                cw.alu_src_a_sel = ALU_A_PC;
                cw.alu_src_b_sel = ALU_B_FOUR;
                cw.alu_op        = ALU_OP_ADD;
                cw.pc_src_sel    = PC_SRC_ALU;
            end
            S_DECODE: begin
                // Speculatively form the branch target while the opcode is decoded
                cw.alu_src_b_sel = ALU_B_BR_OFS;
                cw.illegal_op    = ~op_is_legal(opcode);
            end
            S_MEMADR: begin
                cw.alu_src_a_sel = ALU_A_REG;
                cw.alu_src_b_sel = ALU_B_EXT;
                cw.ext_sel       = EXT_SIGN;
            end
            S_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.iord     = IORD_ALUOUT;
            end
            S_MEMWB: begin
                cw.reg_write      = 1'b1;
                cw.reg_dst_sel    = REG_DST_RT;
                cw.mem_to_reg_sel = MEM_TO_REG_MDR;
                cw.instr_done     = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_write  = 1'b1;
                cw.iord       = IORD_ALUOUT;
                cw.instr_done = 1'b1;
            end
            S_EXEC: begin
                cw.alu_src_a_sel = ALU_A_REG;
                cw.alu_src_b_sel = ALU_B_REG;
                cw.alu_op        = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_write      = 1'b1;
                cw.reg_dst_sel    = REG_DST_RD;
                cw.mem_to_reg_sel = MEM_TO_REG_ALU;
                cw.instr_done     = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a_sel = ALU_A_REG;
                cw.alu_src_b_sel = ALU_B_REG;
                cw.alu_op        = ALU_OP_SUB;
                cw.pc_src_sel    = PC_SRC_ALUOUT;
                cw.pc_write_cond = 1'b1;
                cw.instr_done    = 1'b1;
            end
            S_IMMEXEC: begin
                cw.alu_src_a_sel = ALU_A_REG;
                cw.alu_src_b_sel = ALU_B_EXT;
                if (opcode == OP_ORI) begin
                    cw.ext_sel = EXT_ZERO;
                    cw.alu_op  = ALU_OP_OR;
                end else begin
                    cw.ext_sel = EXT_SIGN;
                    cw.alu_op  = ALU_OP_ADD;
                end
            end
            S_IMMWB: begin
                cw.reg_write      = 1'b1;
                cw.reg_dst_sel    = REG_DST_RT;
                cw.mem_to_reg_sel = MEM_TO_REG_ALU;
                cw.instr_done     = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_src_sel = PC_SRC_JUMP;
                cw.instr_done = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS-lite main control sequencer; MC_CTRL_MEM_WAIT_EN adds memory wait states
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_fsm_if.ctrl bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t cw;
    logic       mem_wait;
    logic       is_bne;
    logic       live;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_wait = ~bus.mem_ready &
                      ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR));
`else
    assign mem_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ORI: state_d = S_IMMEXEC;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_ALUWB;
            S_IMMEXEC: state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
        if (mem_wait) begin
            state_d = state_q;
        end
    end

    mc_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (bus.opcode),
        .cw     (cw)
    );

    // Strobes are gated by rst so an aborted instruction never commits anything
    assign live   = ~rst;
    assign is_bne = (bus.opcode == OP_BNE);

    assign bus.pc_en          = live & ((cw.pc_write & ~mem_wait) |
                                        (cw.pc_write_cond & (bus.zero ^ is_bne)));
    assign bus.mem_read       = live & cw.mem_read;
    assign bus.mem_write      = live & cw.mem_write;
    assign bus.ir_write       = live & cw.ir_write & ~mem_wait;
    assign bus.reg_write      = live & cw.reg_write;
    assign bus.instr_done     = live & cw.instr_done & ~mem_wait;
    assign bus.illegal_op     = live & cw.illegal_op;
    assign bus.iord           = cw.iord;
    assign bus.reg_dst_sel    = cw.reg_dst_sel;
    assign bus.mem_to_reg_sel = cw.mem_to_reg_sel;
    assign bus.alu_src_a_sel  = cw.alu_src_a_sel;
    assign bus.alu_src_b_sel  = cw.alu_src_b_sel;
    assign bus.ext_sel        = cw.ext_sel;
    assign bus.alu_op         = cw.alu_op;
    assign bus.pc_src_sel     = cw.pc_src_sel;
    assign bus.state          = state_q;

endmodule
